msrv32_integer_file: RTL and testbench

Architectural integer register file (x0–x31) of the msrv32 core, directly downstream of the write-enable generator. It consumes `wr_en_int_file_out` as its write enable, takes write-back data and destination address from the stage-3 pipeline register, and serves two combinational read ports to the decode/operand stage. Writes commit on the clock edge. A same-cycle write-to-read bypass removes the read-after-write hazard between write-back and decode. x0 is hardwired to zero.

---
 rtl/msrv32_pkg.sv | 23 ++
 rtl/msrv32_integer_file_if.sv | 33 +++
 rtl/msrv32_rf_read_port.sv | 45 ++++
 rtl/msrv32_integer_file.sv | 79 +++++++
 tb/tb_msrv32_integer_file.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/msrv32_pkg.sv
// -----------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the msrv32 core: the architectural data width, the
// register-address width and count, the x0 address, the matching typedefs,
// and a small helper that recognises the hardwired-zero register.
// -----------------------------------------------------------------------------
package msrv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t X0_ADDR = 5'd0;

    // x0 has no storage: any access to it is short-circuited to zero.
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == X0_ADDR;
    endfunction

endpackage

// File: rtl/msrv32_integer_file_if.sv
// -----------------------------------------------------------------------------
// msrv32_integer_file_if
// Write-back bus of the integer register file: the write enable, destination
// address and data coming from the stage-3 register, plus the reset level
// that disqualifies both the commit and the same-cycle bypass.
//   master : side that drives the write-back bus (register-file top)
//   slave  : side that observes it (read-port muxes)
// -----------------------------------------------------------------------------
interface msrv32_integer_file_if #(
    parameter int XLEN = 32
);
    import msrv32_pkg::*;

    logic            wr_en;
    reg_addr_t       rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rst;

    modport master (
        output wr_en,
        output rd_addr,
        output rd_data,
        output rst
    );

    modport slave (
        input wr_en,
        input rd_addr,
        input rd_data,
        input rst
    );

endinterface

// File: rtl/msrv32_rf_read_port.sv
// -----------------------------------------------------------------------------
// msrv32_rf_read_port
// One combinational read port of the integer register file. Priority:
//   1. address x0            -> zero
//   2. same-cycle write hit  -> write-back data (only when BYPASS_EN != 0
//                               and reset is low)
//   3. otherwise             -> stored register value
// Ports:
//   wb        : write-back bus (slave modport)
//   rs_addr   : read address
//   regs_flat : all 32 registers packed, slot 0 tied to zero
//   rs_data   : read data
// -----------------------------------------------------------------------------
module msrv32_rf_read_port
    import msrv32_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BYPASS_EN = 1
) (
    msrv32_integer_file_if.slave        wb,
    input  reg_addr_t                   rs_addr,
    input  logic [REG_COUNT*XLEN-1:0]   regs_flat,
    output logic [XLEN-1:0]             rs_data
);

    logic            bypass_hit;
    logic [XLEN-1:0] array_data;

    // A write presented while reset is high never commits, so it must not
    // be forwarded either.
    assign bypass_hit = (BYPASS_EN != 0) && wb.wr_en && !wb.rst
                        && (wb.rd_addr == rs_addr);

    assign array_data = regs_flat[int'(rs_addr) * XLEN +: XLEN];

    always_comb begin
        rs_data = array_data;
        if (is_x0(rs_addr)) begin
            rs_data = '0;
        end else if (bypass_hit) begin
            rs_data = wb.rd_data;
        end
    end

endmodule

// File: rtl/msrv32_integer_file.sv
// -----------------------------------------------------------------------------
// msrv32_integer_file
// Architectural integer register file x0..x31 of the msrv32 core. x1..x31 are
// flip-flop registers cleared by synchronous reset; x0 reads as zero and
// ignores writes. Two independent combinational read ports, each with an
// optional same-cycle write-to-read bypass.
// Ports:
//   ms_riscv32_mp_clk_in : core clock, rising edge
//   ms_riscv32_mp_rst_in : synchronous active-high reset (beats a write)
//   rs_1_addr_in / rs_2_addr_in : read addresses
//   rd_addr_in / wr_en_in / rd_in : write-back address, enable, data
//   rs_1_out / rs_2_out : read data
// -----------------------------------------------------------------------------
module msrv32_integer_file
    import msrv32_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  reg_addr_t       rs_1_addr_in,
    input  reg_addr_t       rs_2_addr_in,
    input  reg_addr_t       rd_addr_in,
    input  logic            wr_en_in,
    input  logic [XLEN-1:0] rd_in,
    output logic [XLEN-1:0] rs_1_out,
    output logic [XLEN-1:0] rs_2_out
);

    msrv32_integer_file_if #(.XLEN(XLEN)) wb_bus ();

    assign wb_bus.wr_en   = wr_en_in;
    assign wb_bus.rd_addr = rd_addr_in;
    assign wb_bus.rd_data = rd_in;
    assign wb_bus.rst     = ms_riscv32_mp_rst_in;

    // Flat packed view of the whole file so each read port can index it
    // without a shared unpacked array. Slot 0 is the hardwired-zero x0.
    logic [REG_COUNT*XLEN-1:0] regs_flat;

    assign regs_flat[XLEN-1:0] = '0;

    // Individual registers rather than a RAM: reset must clear every entry.
    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_reg
        logic [XLEN-1:0] value_reg;

        always_ff @(posedge ms_riscv32_mp_clk_in) begin
            if (ms_riscv32_mp_rst_in) begin
                value_reg <= '0;
            end else if (wr_en_in && (rd_addr_in == reg_addr_t'(gi))) begin
                value_reg <= rd_in;
            end
        end

        assign regs_flat[gi*XLEN +: XLEN] = value_reg;
    end

    msrv32_rf_read_port #(
        .XLEN      (XLEN),
        .BYPASS_EN (BYPASS_EN)
    ) u_read_port_1 (
        .wb        (wb_bus),
        .rs_addr   (rs_1_addr_in),
        .regs_flat (regs_flat),
        .rs_data   (rs_1_out)
    );

    msrv32_rf_read_port #(
        .XLEN      (XLEN),
        .BYPASS_EN (BYPASS_EN)
    ) u_read_port_2 (
        .wb        (wb_bus),
        .rs_addr   (rs_2_addr_in),
        .regs_flat (regs_flat),
        .rs_data   (rs_2_out)
    );

endmodule

// File: tb/tb_msrv32_integer_file.sv
// -----------------------------------------------------------------------------
// tb_msrv32_integer_file
// Drives one bypass-enabled and one bypass-disabled register file from the
// same stimulus and compares both read ports of each against an array-based
// reference model of the architectural register state.
// -----------------------------------------------------------------------------
module tb_msrv32_integer_file;

    logic        clk;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] r1_byp, r2_byp, r1_nob, r2_nob;

    msrv32_integer_file_if #(.XLEN(32)) bus ();

    msrv32_integer_file #(.XLEN(32), .BYPASS_EN(1)) dut_byp (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (bus.rst),
        .rs_1_addr_in         (rs1),
        .rs_2_addr_in         (rs2),
        .rd_addr_in           (bus.rd_addr),
        .wr_en_in             (bus.wr_en),
        .rd_in                (bus.rd_data),
        .rs_1_out             (r1_byp),
        .rs_2_out             (r2_byp)
    );

    msrv32_integer_file #(.XLEN(32), .BYPASS_EN(0)) dut_nob (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (bus.rst),
        .rs_1_addr_in         (rs1),
        .rs_2_addr_in         (rs2),
        .rd_addr_in           (bus.rd_addr),
        .wr_en_in             (bus.wr_en),
        .rd_in                (bus.rd_data),
        .rs_1_out             (r1_nob),
        .rs_2_out             (r2_nob)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];

    // Architectural read as seen by decode in the current cycle.
    function automatic logic [31:0] expect_read(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 32'h0;
        if (byp && bus.wr_en && !bus.rst && bus.rd_addr == addr) return bus.rd_data;
        return model[addr];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs just after a rising edge, compare on the
    // falling edge, then commit the architectural effect at the next edge.
    task automatic cycle(input logic r, input logic we, input logic [4:0] rd,
                         input logic [31:0] d, input logic [4:0] a1,
                         input logic [4:0] a2, input bit chk, input string tag);
        bus.rst     = r;
        bus.wr_en   = we;
        bus.rd_addr = rd;
        bus.rd_data = d;
        rs1         = a1;
        rs2         = a2;
        #4;
        if (chk) begin
            check({tag, "/byp/rs1"}, r1_byp, expect_read(a1, 1'b1));
            check({tag, "/byp/rs2"}, r2_byp, expect_read(a2, 1'b1));
            check({tag, "/nob/rs1"}, r1_nob, expect_read(a1, 1'b0));
            check({tag, "/nob/rs2"}, r2_nob, expect_read(a2, 1'b0));
            $display("cycle %s rst=%0b we=%0b rd=%0d d=%h rs1=%0d rs2=%0d byp=%h/%h nob=%h/%h",
                     tag, r, we, rd, d, a1, a2, r1_byp, r2_byp, r1_nob, r2_nob);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && rd != 5'd0) begin
            model[rd] = d;
        end
        #1;
    endtask

    initial begin
        bus.rst = 1'b1; bus.wr_en = 1'b0; bus.rd_addr = '0; bus.rd_data = '0;
        rs1 = '0; rs2 = '0;
        @(posedge clk);
        #1;

        // Reset for two cycles with a write attempt that must be dropped;
        // outputs are only defined once the first reset edge has happened.
        cycle(1'b1, 1'b1, 5'd4, 32'hCAFE_0004, 5'd4, 5'd0, 1'b0, "rst0");
        cycle(1'b1, 1'b1, 5'd4, 32'hCAFE_0004, 5'd4, 5'd31, 1'b1, "rst1");

        // Post-reset sweep of all addresses on both ports.
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, $sformatf("sweep%0d", i));

        // Write/read back including the top address.
        cycle(1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd1, 5'd2, 1'b1, "wr_x5");
        cycle(1'b0, 1'b1, 5'd31, 32'h0000_0001, 5'd5, 5'd3, 1'b1, "wr_x31");
        cycle(1'b0, 1'b0, 5'd0,  32'h0, 5'd5, 5'd31, 1'b1, "rb_5_31");
        cycle(1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd5, 5'd30, 1'b1, "wr_x31_ff");
        cycle(1'b0, 1'b0, 5'd0,  32'h0, 5'd31, 5'd31, 1'b1, "rb_31_ff");

        // x0 immunity, in the write cycle and the one after.
        cycle(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1'b1, "x0_wr");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, "x0_next");

        // Bypass: old value 1111_1111, same-cycle write of 2222_2222.
        cycle(1'b0, 1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0, 1'b1, "x7_init");
        cycle(1'b0, 1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 1'b1, "x7_bypass");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, "x7_next");

        // Flushed write (enable low) must not touch x9 nor the bypass.
        cycle(1'b0, 1'b1, 5'd9, 32'h9999_0009, 5'd0, 5'd0, 1'b1, "x9_init");
        cycle(1'b0, 1'b0, 5'd9, 32'hAAAA_AAAA, 5'd9, 5'd9, 1'b1, "x9_flush");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, "x9_next");

        // Reset colliding with a write: write dropped, no forwarding.
        cycle(1'b0, 1'b1, 5'd3, 32'h0000_0005, 5'd0, 5'd0, 1'b1, "x3_init");
        cycle(1'b1, 1'b1, 5'd3, 32'h0000_0007, 5'd3, 5'd3, 1'b1, "x3_rst_wr");
        check("x3_rst_not7_byp", {31'h0, r1_byp == 32'h7}, 32'h0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b1, "x3_after_rst");
        cycle(1'b0, 1'b1, 5'd3, 32'h0000_0033, 5'd3, 5'd0, 1'b1, "first_wr_after_rst");

        // Randomized traffic with occasional resets and forced bypass hits.
        for (int n = 0; n < 400; n++) begin
            logic        r, we;
            logic [4:0]  rd, a1, a2;
            logic [31:0] d;
            r  = ($urandom_range(0, 31) == 0);
            we = ($urandom_range(0, 3) != 0);
            rd = 5'($urandom_range(0, 31));
            d  = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            cycle(r, we, rd, d, a1, a2, 1'b1, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
